// File: rtl/flappy_bird_control_text_blinker.sv
// rtl/flappy_bird_control_text_blinker.sv - Avalon-MM controlled text-overlay blinker
// Blinks text_on for ON_TIME/OFF_TIME clocks, REPEAT times (0 = forever), with done/irq status.
module flappy_bird_control_text_blinker #(
  parameter int CNT_W = 24,
  parameter int REP_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        text_on,
  output logic        busy,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W-1:0] REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] on_time_q, on_time_d, off_time_q, off_time_d;
  logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [REP_W-1:0] repeat_q, repeat_d, rep_cnt_q, rep_cnt_d;
  logic             rep_finite_q, rep_finite_d;
  logic             static_q, static_d, irq_en_q, irq_en_d;
  logic             done_q, done_d, text_on_q, text_on_d;

  logic wr, wr_ctrl, start, abort, done_clr, phase_end;
  logic wdata_unused;

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr && (address == 2'd0);
  assign start     = wr_ctrl & writedata[0];
  assign abort     = wr_ctrl & writedata[1];
  assign done_clr  = wr_ctrl & writedata[4];
  // Counter value 0 is treated like 1 so a zero reload cannot stall a phase.
  assign phase_end = (phase_cnt_q[CNT_W-1:1] == '0);
  assign wdata_unused = ^writedata;

  always_comb begin
    state_d      = state_q;
    on_time_d    = on_time_q;
    off_time_d   = off_time_q;
    repeat_d     = repeat_q;
    phase_cnt_d  = phase_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    rep_finite_d = rep_finite_q;
    static_d     = static_q;
    irq_en_d     = irq_en_q;
    done_d       = done_q;

    if (wr && address == 2'd1) on_time_d  = writedata[CNT_W-1:0];
    if (wr && address == 2'd2) off_time_d = writedata[CNT_W-1:0];
    if (wr && address == 2'd3) repeat_d   = writedata[REP_W-1:0];
    if (wr_ctrl) begin
      static_d = writedata[2];
      irq_en_d = writedata[3];
    end
    if (done_clr) done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort && on_time_q != '0) begin
          state_d      = S_ON;
          phase_cnt_d  = on_time_q;
          rep_cnt_d    = repeat_q;
          rep_finite_d = (repeat_q != '0);
          done_d       = 1'b0;
        end
      end
      S_ON: begin
        if (!phase_end) begin
          phase_cnt_d = phase_cnt_q - CNT_ONE;
        end else if (rep_finite_q && rep_cnt_q == REP_ONE) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          if (rep_finite_q) rep_cnt_d = rep_cnt_q - REP_ONE;
          if (off_time_q == '0) begin
            phase_cnt_d = on_time_q;
          end else begin
            state_d     = S_OFF;
            phase_cnt_d = off_time_q;
          end
        end
      end
      S_OFF: begin
        if (!phase_end) begin
          phase_cnt_d = phase_cnt_q - CNT_ONE;
        end else begin
          state_d     = S_ON;
          phase_cnt_d = on_time_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort never reports completion, even if the last phase ends on this edge.
    if (abort) begin
      state_d = S_IDLE;
      done_d  = done_clr ? 1'b0 : done_q;
    end

    text_on_d = (state_d == S_ON) ? 1'b1 : (state_d == S_OFF) ? 1'b0 : static_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      on_time_q    <= '0;
      off_time_q   <= '0;
      repeat_q     <= '0;
      phase_cnt_q  <= '0;
      rep_cnt_q    <= '0;
      rep_finite_q <= 1'b0;
      static_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      text_on_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      on_time_q    <= on_time_d;
      off_time_q   <= off_time_d;
      repeat_q     <= repeat_d;
      phase_cnt_q  <= phase_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      rep_finite_q <= rep_finite_d;
      static_q     <= static_d;
      irq_en_q     <= irq_en_d;
      done_q       <= done_d;
      text_on_q    <= text_on_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign irq     = done_q & irq_en_q;
  assign text_on = text_on_q;

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: begin
        readdata[0]          = busy;
        readdata[1]          = done_q;
        readdata[2]          = static_q;
        readdata[3]          = irq_en_q;
        readdata[8 +: REP_W] = rep_cnt_q;
      end
      2'd1:    readdata[CNT_W-1:0] = on_time_q;
      2'd2:    readdata[CNT_W-1:0] = off_time_q;
      default: readdata[REP_W-1:0] = repeat_q;
    endcase
  end

endmodule

// File: tb/tb_flappy_bird_control_text_blinker.sv
// tb/tb_flappy_bird_control_text_blinker.sv - directed and random checks against a cycle-count reference model
module tb_flappy_bird_control_text_blinker;

  logic        clk = 1'b0;
  logic        reset, chipselect, write_n;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;
  logic        text_on, busy, irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flappy_bird_control_text_blinker dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .text_on(text_on), .busy(busy), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase length and clocks elapsed in the phase, plus repeats left.
  int m_on, m_off, m_rep, m_len, m_elapsed, m_reps;
  bit m_static, m_irq_en, m_done, m_active, m_in_on, m_forever;

  task automatic model_step(input bit wr, input logic [1:0] a, input logic [31:0] d, input bit rst);
    bit ctrl, start, abort, clr, nd;
    if (rst) begin
      m_on = 0; m_off = 0; m_rep = 0; m_len = 0; m_elapsed = 0; m_reps = 0;
      m_static = 0; m_irq_en = 0; m_done = 0; m_active = 0; m_in_on = 0; m_forever = 0;
      return;
    end
    ctrl  = wr && (a == 2'd0);
    start = ctrl && d[0];
    abort = ctrl && d[1];
    clr   = ctrl && d[4];
    nd    = clr ? 1'b0 : m_done;
    if (m_active) begin
      if (m_elapsed < m_len) m_elapsed++;
      else if (m_in_on) begin
        if (!m_forever && m_reps == 1) begin
          m_active = 0;
          nd = 1;
        end else begin
          if (!m_forever) m_reps--;
          m_elapsed = 1;
          if (m_off == 0) m_len = m_on;
          else begin m_in_on = 0; m_len = m_off; end
        end
      end else begin
        m_in_on = 1; m_len = m_on; m_elapsed = 1;
      end
    end else if (start && !abort && m_on != 0) begin
      m_active = 1; m_in_on = 1; m_len = m_on; m_elapsed = 1;
      m_reps = m_rep; m_forever = (m_rep == 0); nd = 0;
    end
    if (abort) begin
      m_active = 0;
      nd = clr ? 1'b0 : m_done;
    end
    m_done = nd;
    if (ctrl) begin m_static = d[2]; m_irq_en = d[3]; end
    if (wr && a == 2'd1) m_on  = int'(d[23:0]);
    if (wr && a == 2'd2) m_off = int'(d[23:0]);
    if (wr && a == 2'd3) m_rep = int'(d[7:0]);
  endtask

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return (32'(m_reps) << 8) | (32'(m_irq_en) << 3) | (32'(m_static) << 2) |
                      (32'(m_done) << 1) | 32'(m_active);
      2'd1:    return 32'(m_on);
      2'd2:    return 32'(m_off);
      default: return 32'(m_rep);
    endcase
  endfunction

  task automatic tick(input bit wr, input logic [1:0] a, input logic [31:0] d, input bit rst);
    reset = rst; chipselect = wr; write_n = !wr; address = a; writedata = d;
    @(posedge clk);
    model_step(wr, a, d, rst);
    @(negedge clk);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 2'($urandom_range(0, 3));
    #1;
    check("text_on", 32'(text_on), 32'(m_active ? m_in_on : m_static));
    check("busy", 32'(busy), 32'(m_active));
    check("irq", 32'(irq), 32'(m_done & m_irq_en));
    check("readdata", readdata, exp_rd(address));
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    tick(1'b1, a, d, 1'b0);
  endtask

  task automatic idle();
    tick(1'b0, 2'd0, 32'd0, 1'b0);
  endtask

  initial begin
    bit exp_seq [9];
    int run;
    bit seen_low;
    exp_seq = '{1, 1, 1, 0, 0, 1, 1, 1, 0};
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
    model_step(1'b0, 2'd0, 32'd0, 1'b1);

    tick(1'b0, 2'd0, 32'd0, 1'b1);
    tick(1'b0, 2'd0, 32'd0, 1'b1);
    check("reset_text_on", 32'(text_on), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // 3/2/2 sequence with IRQ enabled, then done clear
    wr_reg(2'd1, 32'd3); wr_reg(2'd2, 32'd2); wr_reg(2'd3, 32'd2);
    wr_reg(2'd0, 32'h9);
    check("seq0", 32'(text_on), 32'(exp_seq[0]));
    for (int i = 1; i < 9; i++) begin
      idle();
      check($sformatf("seq%0d", i), 32'(text_on), 32'(exp_seq[i]));
    end
    check("seq_busy_end", 32'(busy), 32'd0);
    check("seq_irq_set", 32'(irq), 32'd1);
    wr_reg(2'd0, 32'h18);
    check("irq_cleared", 32'(irq), 32'd0);

    // ON_TIME=0 start ignored, text_on follows STATIC
    wr_reg(2'd1, 32'd0);
    wr_reg(2'd0, 32'h5);
    check("on0_busy", 32'(busy), 32'd0);
    check("on0_text", 32'(text_on), 32'd1);

    // START while busy does not restart the sequence
    wr_reg(2'd1, 32'd3);
    wr_reg(2'd0, 32'h1);
    idle();
    wr_reg(2'd0, 32'h1);
    idle();
    check("restart_ignored", 32'(text_on), 32'd0);
    for (int i = 0; i < 8; i++) idle();

    // START together with ABORT stays idle
    wr_reg(2'd0, 32'h3);
    check("start_abort", 32'(busy), 32'd0);

    // reset mid-ON overrides a concurrent write
    wr_reg(2'd0, 32'h1);
    idle();
    tick(1'b1, 2'd1, 32'd7, 1'b1);
    check("rst_text_on", 32'(text_on), 32'd0);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      check($sformatf("rst_rd%0d", a), readdata, 32'd0);
    end

    // OFF_TIME=0: continuous ON for ON*REPEAT clocks
    wr_reg(2'd1, 32'd4); wr_reg(2'd2, 32'd0); wr_reg(2'd3, 32'd3);
    wr_reg(2'd0, 32'h1);
    run = text_on ? 1 : 0;
    seen_low = 1'b0;
    for (int i = 0; i < 14; i++) begin
      idle();
      if (!text_on) seen_low = 1'b1;
      else if (!seen_low) run++;
    end
    check("cont_run", 32'(run), 32'd12);
    address = 2'd0;
    #1;
    check("cont_done", 32'(readdata[1]), 32'd1);

    // infinite blink, then abort with STATIC
    wr_reg(2'd3, 32'd0); wr_reg(2'd1, 32'd2); wr_reg(2'd2, 32'd1);
    wr_reg(2'd0, 32'h1);
    for (int i = 0; i < 30; i++) begin
      check($sformatf("inf%0d", i), 32'(text_on), 32'((i % 3) != 2));
      idle();
    end
    wr_reg(2'd0, 32'h6);
    check("abort_text", 32'(text_on), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    address = 2'd0;
    #1;
    check("abort_done", 32'(readdata[1]), 32'd0);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [31:0] d;
      r = $urandom_range(0, 99);
      if (r < 8) wr_reg(2'd1, m_active ? $urandom_range(1, 5) : $urandom_range(0, 5));
      else if (r < 14) wr_reg(2'd2, $urandom_range(0, 3));
      else if (r < 20) wr_reg(2'd3, $urandom_range(0, 3));
      else if (r < 32) begin
        d = '0;
        d[0] = 1'($urandom_range(0, 1));
        d[1] = ($urandom_range(0, 9) == 0);
        d[2] = 1'($urandom_range(0, 1));
        d[3] = 1'($urandom_range(0, 1));
        d[4] = ($urandom_range(0, 3) == 0);
        wr_reg(2'd0, d);
      end
      else if (r < 33) tick(1'b1, 2'($urandom_range(0, 3)), $urandom, 1'b1);
      else idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
